// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU core: loadable IMEM, register-file DMEM, start/busy/done
// handshake, HLT opcode and cycle-limit watchdog. Optional ACC_CPU_SINGLE_STEP_EN adds `step`.
module acc_cpu_param #(
  parameter int DATA_W     = 8,
  parameter int ARG_W      = 4,
  parameter int MAX_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ARG_W-1:0]  prog_addr,
  input  logic [ARG_W+3:0]  prog_wdata,
  input  logic              start,
`ifdef ACC_CPU_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              busy,
  output logic              done,
  output logic              timeout,
  input  logic [ARG_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [ARG_W-1:0]  pc_out,
  output logic [DATA_W-1:0] acc_out
);

  localparam int DEPTH  = 1 << ARG_W;
  localparam int INST_W = 4 + ARG_W;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_LD   = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SHL  = 4'h6,
    OP_ST   = 4'h7,
    OP_LDI  = 4'h8,
    OP_ADDI = 4'h9,
    OP_SHR  = 4'hA,
    OP_HLT  = 4'hE,
    OP_BNEZ = 4'hF
  } op_t;

  state_t             state;
  logic [INST_W-1:0]  imem [DEPTH];
  logic [DATA_W-1:0]  dmem [DEPTH];
  logic [ARG_W-1:0]   pc;
  logic [DATA_W-1:0]  acc;
  logic [CNT_W-1:0]   cnt;
  logic               busy_q, done_q, timeout_q;

  logic [INST_W-1:0]  inst;
  op_t                op;
  logic [ARG_W-1:0]   arg;
  logic [DATA_W-1:0]  operand;
  logic [DATA_W-1:0]  sext;
  logic [DATA_W-1:0]  acc_nxt;
  logic [ARG_W-1:0]   pc_nxt;
  logic               st_en;
  logic               hlt_op;
  logic               br_taken;
  logic               wd_hit;
  logic               halt;
  logic               exec;

  assign inst    = imem[pc];
  assign op      = op_t'(inst[3:0]);
  assign arg     = inst[4 +: ARG_W];
  assign operand = dmem[arg];
  assign sext    = {{(DATA_W-ARG_W){arg[ARG_W-1]}}, arg};

`ifdef ACC_CPU_SINGLE_STEP_EN
  assign exec = (state == S_RUN) && step;
`else
  assign exec = (state == S_RUN);
`endif

  always_comb begin
    acc_nxt  = acc;
    pc_nxt   = pc + 1'b1;
    st_en    = 1'b0;
    hlt_op   = 1'b0;
    br_taken = 1'b0;
    case (op)
      OP_LD:   acc_nxt = operand;
      OP_ADD:  acc_nxt = acc + operand;
      OP_SUB:  acc_nxt = acc - operand;
      OP_AND:  acc_nxt = acc & operand;
      OP_OR:   acc_nxt = acc | operand;
      OP_XOR:  acc_nxt = acc ^ operand;
      OP_SHL:  acc_nxt = acc << 1;
      OP_ST:   st_en   = 1'b1;
      OP_LDI:  acc_nxt = sext;
      OP_ADDI: acc_nxt = acc + sext;
      OP_SHR:  acc_nxt = acc >> 1;
      OP_HLT:  hlt_op  = 1'b1;
      OP_BNEZ: begin
        if (acc != '0) begin
          pc_nxt   = arg;
          br_taken = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Falling off the last IMEM slot halts unless a taken branch leaves it.
  assign wd_hit = (cnt == CNT_W'(MAX_CYCLES - 1));
  assign halt   = hlt_op || ((pc == '1) && !br_taken) || wd_hit;

  // IMEM is deliberately not reset; writes are blocked only while a run is in flight.
  always_ff @(posedge clk) begin
    if (prog_we && !busy_q)
      imem[prog_addr] <= prog_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      acc       <= '0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++)
        dmem[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state     <= S_RUN;
            pc        <= '0;
            acc       <= '0;
            cnt       <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (exec) begin
            acc <= acc_nxt;
            if (st_en)
              dmem[arg] <= acc;
            if (cnt != '1)
              cnt <= cnt + 1'b1;
            if (halt) begin
              state     <= S_HALT;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              timeout_q <= wd_hit;
            end else begin
              pc <= pc_nxt;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign dbg_data = dmem[dbg_addr];
  assign pc_out   = pc;
  assign acc_out  = acc;

endmodule

// File: tb/tb_acc_cpu_param.sv
// Directed bench for acc_cpu_param: default instance plus a MAX_CYCLES=10 instance for the watchdog.
module tb_acc_cpu_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_wdata = '0;
  logic       start = 1'b0;
  logic [3:0] dbg_addr = '0;
`ifdef ACC_CPU_SINGLE_STEP_EN
  logic       step = 1'b1;
`endif

  logic       busy, done, timeout;
  logic [7:0] dbg_data, acc_out;
  logic [3:0] pc_out;
  logic       busy_w, done_w, timeout_w;
  logic [7:0] dbg_data_w, acc_w;
  logic [3:0] pc_w;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  acc_cpu_param #(.DATA_W(8), .ARG_W(4), .MAX_CYCLES(255)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .start(start),
`ifdef ACC_CPU_SINGLE_STEP_EN
    .step(step),
`endif
    .busy(busy), .done(done), .timeout(timeout), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .pc_out(pc_out), .acc_out(acc_out)
  );

  acc_cpu_param #(.DATA_W(8), .ARG_W(4), .MAX_CYCLES(10)) dut_wd (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .start(start),
`ifdef ACC_CPU_SINGLE_STEP_EN
    .step(step),
`endif
    .busy(busy_w), .done(done_w), .timeout(timeout_w), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data_w), .pc_out(pc_w), .acc_out(acc_w)
  );

  function automatic logic [7:0] ins(input logic [3:0] op, input logic [3:0] arg);
    return {arg, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] addr, input logic [7:0] data);
    prog_we = 1'b1; prog_addr = addr; prog_wdata = data;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts executed cycles of the default instance until it drops busy.
  task automatic run_main(input int limit, output int n);
    n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    nchk++;
    if (busy !== 1'b0) begin
      $display("FAIL run_bound: busy=%b still high after %0d cycles, required 0", busy, n);
      nfail++;
    end
  endtask

  task automatic wait_both_idle();
    int n = 0;
    while ((busy || busy_w) && n < 400) begin
      tick();
      n++;
    end
    nchk++;
    if ((busy || busy_w) !== 1'b0) begin
      $display("FAIL idle_bound: busy=%b busy_w=%b after %0d cycles, required 0 0", busy, busy_w, n);
      nfail++;
    end
  endtask

  task automatic read_dbg(input logic [3:0] a, output logic [7:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_n = 1'b0;
    #3;
    nchk++;
    if ({busy, done, timeout} !== 3'b000) begin
      $display("FAIL reset_flags: busy/done/timeout=%b required 000", {busy, done, timeout});
      nfail++;
    end
    nchk++;
    if (pc_out !== 4'h0 || acc_out !== 8'h00) begin
      $display("FAIL reset_pc_acc: pc=%0h acc=%0h required 0 0", pc_out, acc_out);
      nfail++;
    end
    for (int i = 0; i < 16; i++) begin
      read_dbg(4'(i), d);
      nchk++;
      if (d !== 8'h00) begin
        $display("FAIL reset_dmem[%0d]: got %0h required 00", i, d);
        nfail++;
      end
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int n;
    logic [7:0] d;
    load(4'd0, ins(4'h8, 4'd5));
    load(4'd1, ins(4'h7, 4'd1));
    load(4'd2, ins(4'h1, 4'd1));
    load(4'd3, ins(4'h7, 4'd2));
    load(4'd4, ins(4'hE, 4'd0));
    pulse_start();
    nchk++;
    if (busy !== 1'b1 || pc_out !== 4'h0) begin
      $display("FAIL basic_start: busy=%b pc=%0h required 1 0", busy, pc_out);
      nfail++;
    end
    run_main(50, n);
    nchk++;
    if (n !== 5) begin
      $display("FAIL basic_cycles: got %0d required 5", n);
      nfail++;
    end
    nchk++;
    if (done !== 1'b1 || timeout !== 1'b0 || pc_out !== 4'd4 || acc_out !== 8'h0A) begin
      $display("FAIL basic_end: done=%b timeout=%b pc=%0h acc=%0h required 1 0 4 0a",
               done, timeout, pc_out, acc_out);
      nfail++;
    end
    read_dbg(4'd1, d);
    nchk++;
    if (d !== 8'h05) begin
      $display("FAIL basic_dmem1: got %0h required 05", d);
      nfail++;
    end
    read_dbg(4'd2, d);
    nchk++;
    if (d !== 8'h0A) begin
      $display("FAIL basic_dmem2: got %0h required 0a", d);
      nfail++;
    end
    wait_both_idle();
  endtask

  // Uses dmem[1]=05, dmem[2]=0A left by test_basic.
  task automatic test_alu();
    int n;
    logic [7:0] d;
    logic [7:0] prog [15];
    prog = '{ins(4'h0, 4'd2), ins(4'h2, 4'd1), ins(4'h6, 4'd0), ins(4'h5, 4'd1),
             ins(4'h3, 4'd2), ins(4'h4, 4'd1), ins(4'hA, 4'd0), ins(4'h7, 4'd3),
             ins(4'h8, 4'h8), ins(4'h1, 4'd3), ins(4'h9, 4'd1), ins(4'h7, 4'd4),
             ins(4'h9, 4'hF), ins(4'h7, 4'd5), ins(4'hE, 4'd0)};
    for (int i = 0; i < 15; i++) load(4'(i), prog[i]);
    pulse_start();
    run_main(50, n);
    nchk++;
    if (n !== 15 || pc_out !== 4'd14 || acc_out !== 8'hFF) begin
      $display("FAIL alu_end: cycles=%0d pc=%0h acc=%0h required 15 e ff", n, pc_out, acc_out);
      nfail++;
    end
    read_dbg(4'd3, d);
    nchk++;
    if (d !== 8'h07) begin
      $display("FAIL alu_dmem3: got %0h required 07", d);
      nfail++;
    end
    read_dbg(4'd5, d);
    nchk++;
    if (d !== 8'hFF) begin
      $display("FAIL alu_dmem5: got %0h required ff", d);
      nfail++;
    end
    wait_both_idle();
  endtask

  // LDI 3 / ADDI -1 / BNEZ 1 / ST 0 / HLT executes 9 instructions.
  task automatic test_countdown();
    int n;
    logic [7:0] d;
    load(4'd0, ins(4'h8, 4'd3));
    load(4'd1, ins(4'h9, 4'hF));
    load(4'd2, ins(4'hF, 4'd1));
    load(4'd3, ins(4'h7, 4'd0));
    load(4'd4, ins(4'hE, 4'd0));
    pulse_start();
    run_main(50, n);
    nchk++;
    if (n !== 9 || done !== 1'b1 || pc_out !== 4'd4 || acc_out !== 8'h00) begin
      $display("FAIL countdown_end: cycles=%0d done=%b pc=%0h acc=%0h required 9 1 4 00",
               n, done, pc_out, acc_out);
      nfail++;
    end
    read_dbg(4'd0, d);
    nchk++;
    if (d !== 8'h00) begin
      $display("FAIL countdown_dmem0: got %0h required 00", d);
      nfail++;
    end
    wait_both_idle();
  endtask

  task automatic test_watchdog();
    int n = 0;
    load(4'd0, ins(4'h8, 4'd1));
    load(4'd1, ins(4'hF, 4'd1));
    pulse_start();
    while (busy_w && n < 50) begin
      tick();
      n++;
    end
    nchk++;
    if (n !== 10 || done_w !== 1'b1 || timeout_w !== 1'b1 || pc_w !== 4'd1) begin
      $display("FAIL wd_end: cycles=%0d done=%b timeout=%b pc=%0h required 10 1 1 1",
               n, done_w, timeout_w, pc_w);
      nfail++;
    end
    wait_both_idle();
    nchk++;
    if (timeout !== 1'b1 || done !== 1'b1 || pc_out !== 4'd1) begin
      $display("FAIL wd_default_end: timeout=%b done=%b pc=%0h required 1 1 1", timeout, done, pc_out);
      nfail++;
    end
    pulse_start();
    nchk++;
    if ({busy_w, done_w, timeout_w} !== 3'b100) begin
      $display("FAIL wd_restart: busy/done/timeout=%b required 100", {busy_w, done_w, timeout_w});
      nfail++;
    end
    wait_both_idle();
  endtask

  // A HLT written to slot 10 mid-run must be dropped, so the run still falls off at 15.
  task automatic test_falloff();
    int n = 0;
    for (int i = 0; i < 16; i++) load(4'(i), ins(4'hB, 4'd0));
    pulse_start();
    tick(); n++;
    tick(); n++;
    prog_we = 1'b1; prog_addr = 4'd10; prog_wdata = ins(4'hE, 4'd0);
    tick(); n++;
    prog_we = 1'b0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    nchk++;
    if (n !== 16 || pc_out !== 4'd15 || done !== 1'b1 || timeout !== 1'b0) begin
      $display("FAIL falloff_end: cycles=%0d pc=%0h done=%b timeout=%b required 16 f 1 0",
               n, pc_out, done, timeout);
      nfail++;
    end
    wait_both_idle();
  endtask

`ifdef ACC_CPU_SINGLE_STEP_EN
  task automatic test_step();
    step = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) tick();
    nchk++;
    if (busy !== 1'b1 || pc_out !== 4'd0 || acc_out !== 8'h00) begin
      $display("FAIL step_hold: busy=%b pc=%0h acc=%0h required 1 0 00", busy, pc_out, acc_out);
      nfail++;
    end
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
    end
    nchk++;
    if (pc_out !== 4'd3 || busy !== 1'b1) begin
      $display("FAIL step_pulses: pc=%0h busy=%b required 3 1", pc_out, busy);
      nfail++;
    end
    step = 1'b1;
    wait_both_idle();
  endtask
`endif

  task automatic test_prog_with_start();
    int n;
    load(4'd1, ins(4'hE, 4'd0));
    prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = ins(4'h8, 4'd7);
    start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    run_main(50, n);
    nchk++;
    if (n !== 2 || acc_out !== 8'h07 || pc_out !== 4'd1) begin
      $display("FAIL prog_start: cycles=%0d acc=%0h pc=%0h required 2 07 1", n, acc_out, pc_out);
      nfail++;
    end
    wait_both_idle();
  endtask

  task automatic test_reset_midrun();
    logic [7:0] d;
    load(4'd0, ins(4'h8, 4'd6));
    load(4'd1, ins(4'hB, 4'd0));
    pulse_start();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({busy, done} !== 2'b00 || pc_out !== 4'd0 || acc_out !== 8'h00) begin
      $display("FAIL abort: busy=%b done=%b pc=%0h acc=%0h required 0 0 0 00",
               busy, done, pc_out, acc_out);
      nfail++;
    end
    read_dbg(4'd2, d);
    nchk++;
    if (d !== 8'h00) begin
      $display("FAIL abort_dmem2: got %0h required 00", d);
      nfail++;
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alu();
    test_countdown();
    test_watchdog();
    test_falloff();
`ifdef ACC_CPU_SINGLE_STEP_EN
    test_step();
`endif
    test_prog_with_start();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
